// File: rtl/ntt_pkg.sv
// Shared NTT datapath types, mode encodings and modulus constants.
// The operand range helper is used by ntt_pointwise_mult when PWM_RANGE_CHECK_EN is defined.
package ntt_pkg;

  localparam int W = 100;
  localparam int N = 8;
  localparam logic [63:0] Modulus_Q = 64'd2147483777;
  localparam int QW = $clog2(Modulus_Q);

  typedef logic [W-1:0] coeff_t;
  typedef coeff_t vec_t [0:N-1];

  localparam logic NTT_MODE_FWD = 1'b0;
  localparam logic NTT_MODE_INV = 1'b1;

  typedef enum logic {
    EMPTY  = 1'b0,
    HOLD_A = 1'b1
  } pair_state_e;

  // A full-width compare catches both >= Q and any stray bits above QW.
  function automatic logic coeff_out_of_range(input coeff_t c);
    coeff_t q_ext;
    q_ext = W'(Modulus_Q);
    return (c >= q_ext);
  endfunction

endpackage

// File: rtl/ntt_pointwise_mult_lane.sv
// mod_mult_lane: one two-stage modular multiplier lane (product, then reduction)
// with a valid bit travelling alongside the data.
module mod_mult_lane
  import ntt_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  input  logic [QW-1:0] a,
  input  logic [QW-1:0] b,
  output logic          out_valid,
  output logic [QW-1:0] result
);

  localparam logic [2*QW-1:0] MOD_2W = (2*QW)'(Modulus_Q);

  logic [2*QW-1:0] prod_s;
  logic [2*QW-1:0] prod_r;
  logic [QW-1:0]   rem_s;
  logic            s1_valid_r;
  logic            out_valid_r;
  logic [QW-1:0]   result_r;

  // Full-width product and its reduction, each feeding one register stage.
  always_comb begin
    prod_s = {{QW{1'b0}}, a} * {{QW{1'b0}}, b};
    rem_s  = QW'(prod_r % MOD_2W);
  end

  // Stage 1: raw product.
  always_ff @(posedge clk) begin
    if (!reset) begin
      s1_valid_r <= 1'b0;
      prod_r     <= '0;
    end else begin
      s1_valid_r <= in_valid;
      if (in_valid) prod_r <= prod_s;
      else          prod_r <= prod_r;
    end
  end

  // Stage 2: reduced result; holds between valid pulses.
  always_ff @(posedge clk) begin
    if (!reset) begin
      out_valid_r <= 1'b0;
      result_r    <= '0;
    end else begin
      out_valid_r <= s1_valid_r;
      if (s1_valid_r) result_r <= rem_s;
      else            result_r <= result_r;
    end
  end

  assign out_valid = out_valid_r;
  assign result    = result_r;

endmodule

// File: rtl/ntt_pointwise_mult.sv
// Pairs consecutive forward-NTT vectors (A then B) and emits A*B mod Q tagged for iNTT.
// Optional operand range flag is built when PWM_RANGE_CHECK_EN is defined.
module ntt_pointwise_mult
  import ntt_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         data_valid_in,
  input  logic         mode_in,
  input  logic [W-1:0] Data_in [0:N-1],
  input  logic         pair_flush,
  output logic [W-1:0] Data_out [0:N-1],
  output logic         data_valid_out,
  output logic         iNTT_mode_out,
  output logic         pair_pending,
  output logic         range_err
);

  pair_state_e   state_r;
  pair_state_e   state_next_s;
  logic          accept_s;
  logic          load_a_s;
  logic          issue_s;
  logic          pair_pending_r;
  logic          issue_d1_r;
  logic          intt_mode_r;
  logic [QW-1:0] a_r          [0:N-1];
  logic [QW-1:0] lane_result_s [0:N-1];
  logic [N-1:0]  lane_valid_s;
  logic          unused_lane_valid_s;

  assign accept_s = data_valid_in && (mode_in == NTT_MODE_FWD);

  // Pairing FSM: next state plus load/issue strobes.
  always_comb begin
    state_next_s = state_r;
    load_a_s     = 1'b0;
    issue_s      = 1'b0;
    case (state_r)
      EMPTY: begin
        if (accept_s) begin
          load_a_s     = 1'b1;
          state_next_s = HOLD_A;
        end else begin
          state_next_s = EMPTY;
        end
      end
      HOLD_A: begin
        // A flush together with a vector replaces A instead of pairing with it.
        if (accept_s && pair_flush) begin
          load_a_s     = 1'b1;
          state_next_s = HOLD_A;
        end else if (accept_s) begin
          issue_s      = 1'b1;
          state_next_s = EMPTY;
        end else if (pair_flush) begin
          state_next_s = EMPTY;
        end else begin
          state_next_s = HOLD_A;
        end
      end
      default: begin
        state_next_s = EMPTY;
      end
    endcase
  end

  // FSM state, pending flag and the iNTT tag pipeline.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r        <= EMPTY;
      pair_pending_r <= 1'b0;
      issue_d1_r     <= 1'b0;
      intt_mode_r    <= 1'b0;
    end else begin
      state_r        <= state_next_s;
      pair_pending_r <= (state_next_s == HOLD_A);
      issue_d1_r     <= issue_s;
      intt_mode_r    <= issue_d1_r ? NTT_MODE_INV : 1'b0;
    end
  end

  // Held A operand, truncated to the arithmetic width.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < N; i++) a_r[i] <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (load_a_s) a_r[i] <= Data_in[i][QW-1:0];
        else          a_r[i] <= a_r[i];
      end
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_lane
    mod_mult_lane u_lane (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (issue_s),
      .a         (a_r[i]),
      .b         (Data_in[i][QW-1:0]),
      .out_valid (lane_valid_s[i]),
      .result    (lane_result_s[i])
    );
    assign Data_out[i] = {{(W-QW){1'b0}}, lane_result_s[i]};
  end

  // All lanes share one valid stream; lane 0 speaks for them.
  assign data_valid_out      = lane_valid_s[0];
  assign unused_lane_valid_s = ^lane_valid_s[N-1:1];
  assign iNTT_mode_out       = intt_mode_r;
  assign pair_pending        = pair_pending_r;

`ifdef PWM_RANGE_CHECK_EN
  logic range_hit_s;
  logic range_err_r;

  // Any out-of-range lane in the current input vector.
  always_comb begin
    range_hit_s = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (coeff_out_of_range(Data_in[i])) range_hit_s = 1'b1;
      else                                range_hit_s = range_hit_s;
    end
  end

  // Sticky flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      range_err_r <= 1'b0;
    end else if (accept_s && range_hit_s) begin
      range_err_r <= 1'b1;
    end else begin
      range_err_r <= range_err_r;
    end
  end

  assign range_err = range_err_r;
`else
  logic unused_data_hi_s;

  // Upper operand bits are ignored when no range check is built.
  always_comb begin
    unused_data_hi_s = 1'b0;
    for (int i = 0; i < N; i++) unused_data_hi_s = unused_data_hi_s ^ (^Data_in[i][W-1:QW]);
  end

  assign range_err = 1'b0;
`endif

endmodule
